// File: rtl/seg7_pkg.sv
// Shared constants, glyph encodings and types for the status display.
// Glyphs are 7-bit active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] glyph_t;

    localparam logic [3:0] CODE_MAX  = 4'd10;
    localparam logic [3:0] CODE_DEAD = 4'd15;

    localparam glyph_t GLY_0     = 7'h40;
    localparam glyph_t GLY_1     = 7'h79;
    localparam glyph_t GLY_2     = 7'h24;
    localparam glyph_t GLY_3     = 7'h30;
    localparam glyph_t GLY_4     = 7'h19;
    localparam glyph_t GLY_5     = 7'h12;
    localparam glyph_t GLY_6     = 7'h02;
    localparam glyph_t GLY_7     = 7'h78;
    localparam glyph_t GLY_8     = 7'h00;
    localparam glyph_t GLY_9     = 7'h10;
    localparam glyph_t GLY_D     = 7'h21;
    localparam glyph_t GLY_E     = 7'h06;
    localparam glyph_t GLY_A     = 7'h08;
    localparam glyph_t GLY_DASH  = 7'h3F;
    localparam glyph_t GLY_BLANK = 7'h7F;

    // Decimal digit to glyph; out-of-range values render blank.
    function automatic glyph_t digit_glyph(input logic [3:0] v);
        case (v)
            4'd0:    digit_glyph = GLY_0;
            4'd1:    digit_glyph = GLY_1;
            4'd2:    digit_glyph = GLY_2;
            4'd3:    digit_glyph = GLY_3;
            4'd4:    digit_glyph = GLY_4;
            4'd5:    digit_glyph = GLY_5;
            4'd6:    digit_glyph = GLY_6;
            4'd7:    digit_glyph = GLY_7;
            4'd8:    digit_glyph = GLY_8;
            4'd9:    digit_glyph = GLY_9;
            default: digit_glyph = GLY_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph lookup: {state code, digit index} -> segment pattern.
// Digit 0 is the rightmost position.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic [1:0] i_dig,
    output glyph_t     o_glyph
);

    logic [3:0] w_remain;

    // Remaining seconds on the ones digit; code 0 means ten left, whose ones digit is 0.
    assign w_remain = (i_code == 4'd0) ? 4'd0 : 4'(CODE_MAX - i_code);

    // Select glyph for the requested digit position.
    always_comb begin
        o_glyph = GLY_BLANK;
        if (i_code == CODE_DEAD) begin
            case (i_dig)
                2'd0:    o_glyph = GLY_D;
                2'd1:    o_glyph = GLY_A;
                2'd2:    o_glyph = GLY_E;
                default: o_glyph = GLY_D;
            endcase
        end else if (i_code > CODE_MAX) begin
            o_glyph = GLY_DASH;
        end else if (i_dig == 2'd0) begin
            o_glyph = digit_glyph(w_remain);
        end else if ((i_dig == 2'd1) && (i_code == 4'd0)) begin
            o_glyph = GLY_1;
        end
    end

endmodule

// File: rtl/seg7_status_display.sv
// Four-digit multiplexed common-anode display for the self-destruct state code.
// Optional build macro: SEG7_HEARTBEAT_EN lights the d0 decimal point on the
// blink phase while counting, as an alive indicator.
module seg7_status_display
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 2500,
    parameter int unsigned BLINK_SLOTS = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SLOT_W  = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [3:0]         r_code_q;
    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_dig;
    logic [SLOT_W-1:0]  r_slot;
    logic               r_blink;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_dp;

    logic               w_presc_wrap;
    logic               w_slot_wrap;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [1:0]         w_dig_nxt;
    logic [SLOT_W-1:0]  w_slot_nxt;
    logic               w_blink_nxt;
    logic               w_dark;
    glyph_t             w_glyph;
    logic [6:0]         w_seg_nxt;
    logic [3:0]         w_an_nxt;
    logic               w_dp_nxt;

    // Scan timing; outputs are built from next-state counters so they line up with the counter registers.
    always_comb begin
        w_presc_wrap = (r_presc == PRESC_W'(SCAN_DIV - 1));
        w_slot_wrap  = w_presc_wrap && (r_slot == SLOT_W'(BLINK_SLOTS - 1));
        w_presc_nxt  = w_presc_wrap ? '0 : r_presc + PRESC_W'(1);
        w_dig_nxt    = w_presc_wrap ? r_dig + 2'd1 : r_dig;
        w_slot_nxt   = r_slot;
        if (w_presc_wrap) begin
            w_slot_nxt = w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
        end
        w_blink_nxt  = r_blink ^ w_slot_wrap;
    end

    seg7_glyph_rom u_glyph_rom (
        .i_code  (r_code_q),
        .i_dig   (w_dig_nxt),
        .o_glyph (w_glyph)
    );

    // Anti-ghost gap on the first prescaler cycle of a slot, plus the dead-code blink-off phase.
    always_comb begin
        w_dark    = (w_presc_nxt == '0) || ((r_code_q == CODE_DEAD) && w_blink_nxt);
        w_an_nxt  = w_dark ? 4'hF : ~(4'b0001 << w_dig_nxt);
        w_seg_nxt = w_dark ? GLY_BLANK : w_glyph;
`ifdef SEG7_HEARTBEAT_EN
        w_dp_nxt  = !(!w_dark && (w_dig_nxt == 2'd0) && !w_blink_nxt && (r_code_q <= CODE_MAX));
`else
        w_dp_nxt  = 1'b1;
`endif
    end

    // Code capture, scan counters and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_q <= 4'd0;
            r_presc  <= '0;
            r_dig    <= 2'd0;
            r_slot   <= '0;
            r_blink  <= 1'b0;
            r_seg    <= 7'h7F;
            r_an     <= 4'hF;
            r_dp     <= 1'b1;
        end else begin
            r_code_q <= code_in;
            r_presc  <= w_presc_nxt;
            r_dig    <= w_dig_nxt;
            r_slot   <= w_slot_nxt;
            r_blink  <= w_blink_nxt;
            r_seg    <= w_seg_nxt;
            r_an     <= w_an_nxt;
            r_dp     <= w_dp_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule
